// File: rtl/ysyx_20020207_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_20020207_fetch_queue
// Purpose  : Multi-cycle instruction fetch stage. Owns the PC, issues
//            pipelined requests on a valid/ready memory port, buffers
//            in-order responses with their PC in a FIFO and hands them to
//            decode over valid/ready. Handles jump redirects by discarding
//            stale in-flight fetches and raises a sticky halt once an ebreak
//            has been consumed.
// Ports    : clock, reset (sync, active-low)
//            req_valid/req_ready/req_addr      - fetch request port
//            rsp_valid/rsp_data                - in-order fetch responses
//            jump/upc                          - redirect from EXU
//            inst_valid/inst_ready/inst/inst_pc - instruction to IDU
//            halt                              - sticky halt after ebreak
// Options  : FETCH_BYPASS_EN - when defined, a response arriving while the
//            FIFO is empty (and not being dropped) is presented to decode in
//            the same cycle and, if accepted, never written to the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_20020207_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    input  logic            jump,
    input  logic [XLEN-1:0] upc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            halt
);

    localparam int              c_PTR_W   = $clog2(DEPTH);
    localparam int              c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0] c_CREDITS = (c_CNT_W + 1)'(DEPTH);
    localparam logic [XLEN-1:0] c_EBREAK  = XLEN'(32'h0010_0073);
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_fifo_pc   [DEPTH];
    logic [XLEN-1:0]    r_fifo_inst [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_drop;
    // PC of every request in flight, popped in order as responses return
    logic [XLEN-1:0]    r_tag       [DEPTH];
    logic [c_PTR_W-1:0] r_tag_rd;
    logic [c_PTR_W-1:0] r_tag_wr;
    logic               r_halt;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_credit;
    logic [c_CNT_W:0]   w_in_use;
    logic               w_req_fire;
    logic               w_fifo_empty;
    logic               w_rsp_drop;
    logic               w_rsp_keep;
    logic               w_bypass;
    logic               w_consume;
    logic               w_pop;
    logic               w_push;
    logic [c_CNT_W-1:0] w_outstanding_nxt;

    // In-flight plus buffered fetches never exceed DEPTH, which guarantees
    // every returning response has a FIFO slot (no backpressure needed).
    assign w_in_use  = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_credit  = (w_in_use < c_CREDITS);

    // Outputs are qualified with reset so the reset cycle itself is quiet.
    assign req_valid = reset & ~r_halt & w_credit;
    assign req_addr  = reset ? r_pc : RESET_PC;
    assign halt      = r_halt;

    assign w_req_fire   = req_valid & req_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_rsp_drop   = rsp_valid & (r_drop != '0);
    assign w_rsp_keep   = rsp_valid & (r_drop == '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_rsp_keep & w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        inst_valid = 1'b0;
        inst       = '0;
        inst_pc    = '0;
        if (reset) begin
            if (!w_fifo_empty) begin
                inst_valid = 1'b1;
                inst       = r_fifo_inst[r_rd_ptr];
                inst_pc    = r_fifo_pc[r_rd_ptr];
            end else if (w_bypass) begin
                inst_valid = 1'b1;
                inst       = rsp_data;
                inst_pc    = r_tag[r_tag_rd];
            end
        end
    end

    assign w_consume = inst_valid & inst_ready;
    assign w_pop     = w_consume & ~w_fifo_empty;
    // A kept response is buffered unless decode takes it straight from the
    // bypass path, or a jump flushes the FIFO in this very cycle anyway.
    assign w_push    = w_rsp_keep & ~(w_bypass & inst_ready) & ~jump;

    assign w_outstanding_nxt = r_outstanding
                             + (w_req_fire ? c_CNT_ONE : '0)
                             - (rsp_valid  ? c_CNT_ONE : '0);

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
            r_halt        <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_nxt;

            if (w_req_fire) begin
                r_tag_wr <= r_tag_wr + c_PTR_ONE;
            end
            if (rsp_valid) begin
                r_tag_rd <= r_tag_rd + c_PTR_ONE;
            end

            // ebreak retires even when a jump lands in the same cycle
            if (w_consume && (inst == c_EBREAK)) begin
                r_halt <= 1'b1;
            end

            if (jump) begin
                // Every fetch still in flight after this edge (including one
                // accepted now, which carried the old PC) is stale.
                r_pc     <= upc;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_drop   <= w_outstanding_nxt;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + c_PC_STEP;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                r_count <= r_count
                         + (w_push ? c_CNT_ONE : '0)
                         - (w_pop  ? c_CNT_ONE : '0);
                if (w_rsp_drop) begin
                    r_drop <= r_drop - c_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage arrays: contents are only observed through the counters and
    // pointers above, so they need no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_req_fire) begin
            r_tag[r_tag_wr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_tag[r_tag_rd];
            r_fifo_inst[r_wr_ptr] <= rsp_data;
        end
    end

    // A response with nothing outstanding means the memory side broke the
    // request/response ordering contract.
    always_ff @(posedge clock) begin
        if (reset && rsp_valid) begin
            a_rsp_has_request: assert (r_outstanding != '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_20020207_fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ysyx_20020207_fetch_queue
// Purpose  : Self-checking bench for ysyx_20020207_fetch_queue. A queue-based
//            model tracks each in-flight fetch with a stale flag and the
//            decode FIFO as a list of {pc, inst}; a memory model returns
//            in-order responses after a configurable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_20020207_fetch_queue;

    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        jump = 1'b0;
    logic [31:0] upc = '0;
    logic        inst_ready = 1'b0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halt;

    ysyx_20020207_fetch_queue #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .jump       (jump),
        .upc        (upc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .halt       (halt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic [31:0] m_pc = RST_PC;
    bit          m_halt = 1'b0;
    logic [31:0] m_fifo_pc[$];
    logic [31:0] m_fifo_inst[$];
    logic [31:0] m_if_pc[$];
    bit          m_if_stale[$];
    int          n_drop = 0;

    // memory model
    logic [31:0] mem_data[$];
    int          mem_due[$];
    int          mem_last_due = -1;
    int          lat = 1;
    bit          ebreak_en = 1'b0;
    logic [31:0] ebreak_addr = '0;
    int          cyc = 0;

    // DUT observations
    logic [31:0] fire_log[$];
    logic [31:0] cons_log[$];
    logic        last_req_valid;
    logic [31:0] last_req_addr;
    logic        last_inst_valid;
    logic        last_halt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (ebreak_en && a == ebreak_addr) return EBREAK;
        w = {a[15:0] ^ 16'hC3A5, a[31:16]};
        if (w == EBREAK) w = ~w;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input bit rn, input bit rr, input bit ir, input bit j,
                         input logic [31:0] u);
        bit          m_rv, m_iv, byp, fire, cons, rsp, rstale;
        logic [31:0] m_ipc, m_inst, rpc, rdat;
        int          due;
        @(negedge clock);
        reset      = rn;
        req_ready  = rr;
        inst_ready = ir;
        jump       = j;
        upc        = u;
        rsp        = rn && (mem_data.size() > 0) && (mem_due[0] <= cyc);
        rsp_valid  = rsp;
        rsp_data   = rsp ? mem_data[0] : 32'h0;

        m_rv  = rn && !m_halt && (m_if_pc.size() + m_fifo_pc.size() < DEPTH);
        byp   = 1'b0;
        m_iv  = 1'b0;
        m_ipc = '0;
        m_inst = '0;
        if (m_fifo_pc.size() > 0) begin
            m_iv   = 1'b1;
            m_ipc  = m_fifo_pc[0];
            m_inst = m_fifo_inst[0];
        end
`ifdef FETCH_BYPASS_EN
        else if (rsp && !m_if_stale[0]) begin
            byp    = 1'b1;
            m_iv   = 1'b1;
            m_ipc  = m_if_pc[0];
            m_inst = mem_data[0];
        end
`endif
        if (!rn) m_iv = 1'b0;

        #1;
        chk("req_valid", {31'b0, req_valid}, {31'b0, m_rv});
        if (rn) chk("req_addr", req_addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_iv});
        if (m_iv) begin
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_ipc);
        end
        if (rn) chk("halt", {31'b0, halt}, {31'b0, m_halt});

        last_req_valid  = req_valid;
        last_req_addr   = req_addr;
        last_inst_valid = inst_valid;
        last_halt       = halt;
        if (req_valid && req_ready) fire_log.push_back(req_addr);
        if (inst_valid && inst_ready) cons_log.push_back(inst_pc);

        if (!rn) begin
            m_pc   = RST_PC;
            m_halt = 1'b0;
            m_fifo_pc.delete();
            m_fifo_inst.delete();
            m_if_pc.delete();
            m_if_stale.delete();
            mem_data.delete();
            mem_due.delete();
            mem_last_due = -1;
        end else begin
            fire = m_rv && rr;
            cons = m_iv && ir;
            if (cons) begin
                if (m_inst == EBREAK) m_halt = 1'b1;
                if (!byp) begin
                    void'(m_fifo_pc.pop_front());
                    void'(m_fifo_inst.pop_front());
                end
            end
            if (rsp) begin
                rpc    = m_if_pc.pop_front();
                rstale = m_if_stale.pop_front();
                rdat   = mem_data.pop_front();
                void'(mem_due.pop_front());
                if (rstale) n_drop++;
                else if (!(byp && cons)) begin
                    m_fifo_pc.push_back(rpc);
                    m_fifo_inst.push_back(rdat);
                end
            end
            if (fire) begin
                m_if_pc.push_back(m_pc);
                m_if_stale.push_back(j);
                mem_data.push_back(mem_word(m_pc));
                due = cyc + lat;
                if (due <= mem_last_due) due = mem_last_due + 1;
                mem_due.push_back(due);
                mem_last_due = due;
            end
            if (j) begin
                m_fifo_pc.delete();
                m_fifo_inst.delete();
                foreach (m_if_stale[k]) m_if_stale[k] = 1'b1;
                m_pc = u;
            end else if (fire) begin
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input bit rr, input bit ir);
        for (int i = 0; i < n; i++) cycle(1'b1, rr, ir, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        fire_log.delete();
        cons_log.delete();
    endtask

    initial begin
        int d0, f0;
        bit rn, rr, ir, j;
        logic [31:0] u;

        // reset values and back-to-back streaming with 1-cycle memory
        lat = 1;
        do_reset();
        chk("rst_req_valid", {31'b0, last_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, last_inst_valid}, 32'd0);
        run(8, 1'b1, 1'b1);
        chk("stream_req0", fire_log[0], 32'h8000_0000);
        chk("stream_req1", fire_log[1], 32'h8000_0004);
        chk("stream_req2", fire_log[2], 32'h8000_0008);
        chk("stream_fire_cnt", fire_log.size(), 32'd8);
        chk("stream_pc0", cons_log[0], 32'h8000_0000);
        chk("stream_pc2", cons_log[2], 32'h8000_0008);

        // decode stalled: credits run out after DEPTH requests
        do_reset();
        run(10, 1'b1, 1'b0);
        chk("stall_fires", fire_log.size(), DEPTH);
        chk("stall_req_valid", {31'b0, last_req_valid}, 32'd0);
        run(8, 1'b1, 1'b1);
        for (int k = 0; k < DEPTH; k++)
            chk("stall_order", cons_log[k], RST_PC + 32'(4 * k));

        // jump with two in flight plus a third handshake, 3-cycle memory
        lat = 3;
        do_reset();
        d0 = n_drop;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0100);
        run(12, 1'b1, 1'b1);
        chk("jump_drops", n_drop - d0, 32'd3);
        chk("jump_first_req", fire_log[3], 32'h8000_0100);
        chk("jump_first_pc", cons_log[0], 32'h8000_0100);

        // ebreak at 0x8000000C halts fetching; in-flight work drains
        lat = 2;
        ebreak_en = 1'b1;
        ebreak_addr = 32'h8000_000C;
        do_reset();
        run(12, 1'b1, 1'b1);
        chk("halt_set", {31'b0, last_halt}, 32'd1);
        chk("halt_pc", cons_log[3], 32'h8000_000C);
        f0 = fire_log.size();
        run(8, 1'b1, 1'b1);
        chk("halt_no_req", fire_log.size(), f0);
        chk("halt_req_valid", {31'b0, last_req_valid}, 32'd0);
        chk("halt_drained", {31'b0, last_inst_valid}, 32'd0);
        chk("halt_sticky", {31'b0, last_halt}, 32'd1);
        ebreak_en = 1'b0;
        do_reset();
        run(1, 1'b1, 1'b1);
        chk("halt_cleared", {31'b0, last_halt}, 32'd0);

        // jump while the request is stalled
        lat = 1;
        do_reset();
        run(4, 1'b1, 1'b1);
        d0 = n_drop;
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0200);
        chk("stall_jump_addr_before", last_req_addr, 32'h8000_0010);
        cons_log.delete();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_jump_addr_after", last_req_addr, 32'h8000_0200);
        chk("stall_jump_drops", n_drop - d0, 32'd0);
        run(4, 1'b1, 1'b1);
        chk("stall_jump_pc", cons_log[0], 32'h8000_0200);

        // reset mid-stream with two in flight
        lat = 3;
        do_reset();
        run(2, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("midrst_req_valid", {31'b0, last_req_valid}, 32'd0);
        chk("midrst_inst_valid", {31'b0, last_inst_valid}, 32'd0);
        fire_log.delete();
        cons_log.delete();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("midrst_req_addr", last_req_addr, RST_PC);
        chk("midrst_restart", {31'b0, last_req_valid}, 32'd1);
        run(10, 1'b1, 1'b1);
        chk("midrst_first_pc", cons_log[0], RST_PC);

        // randomized traffic, including PC wrap and occasional ebreak/reset
        ebreak_en = 1'b1;
        ebreak_addr = 32'h8000_00F0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) lat = $urandom_range(1, 4);
            rn = ($urandom_range(0, 149) != 0);
            rr = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 9) < 7);
            j  = ($urandom_range(0, 19) == 0);
            u  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8
                                             : (32'h8000_0000 | ($urandom & 32'h0000_00FC));
            cycle(rn, rr, ir, j, u);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
